// File: rtl/pdm_pkg.sv
// Shared definitions for the I2S receiver front end feeding audio_dsm.
//   DW_DEF      : default output word width
//   i2s_state_t : receiver frame-tracking state
//   OB_MSB_MASK : offset-binary MSB flip mask for the default width
package pdm_pkg;

    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_t;

    localparam logic [DW_DEF-1:0] OB_MSB_MASK = {1'b1, {(DW_DEF-1){1'b0}}};

    // Flip mask for an arbitrary width: MSB set only for offset-binary output.
    function automatic logic [63:0] ob_mask64(input logic signed_data, input int dw);
        logic [63:0] m;
        m = '0;
        if (!signed_data) m[dw-1] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/i2s_rx_sync_edge.sv
// sync_edge: N-stage synchroniser with a rising-edge detector on one signal,
// plus plain N-stage synchronisers (same depth, so all outputs stay aligned)
// for W companion signals.
//   clk, rstn  : system clock, async active-low reset
//   edge_in    : signal to synchronise and edge-detect (bck)
//   plain_in   : signals to synchronise only (lrck, sdi)
//   rise       : one-clk pulse on synchronised 0->1 of edge_in
//   plain_out  : synchronised plain_in
module sync_edge #(
    parameter int N = 2,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         edge_in,
    input  logic [W-1:0] plain_in,
    output logic         rise,
    output logic [W-1:0] plain_out
);

    logic [N-1:0]        e_sr;
    logic                e_d;
    logic [N-1:0][W-1:0] p_sr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            e_sr <= '0;
            e_d  <= 1'b0;
            p_sr <= '0;
        end else begin
            e_sr[0] <= edge_in;
            p_sr[0] <= plain_in;
            for (int i = 1; i < N; i++) begin
                e_sr[i] <= e_sr[i-1];
                p_sr[i] <= p_sr[i-1];
            end
            e_d <= e_sr[N-1];
        end
    end

    assign rise      = e_sr[N-1] & ~e_d;
    assign plain_out = p_sr[N-1];

endmodule

// File: rtl/i2s_rx.sv
// i2s_rx: I2S slave receiver. Oversamples bck/lrck/sdi on clk, assembles
// MSB-first words and emits one left/right pair per lrck frame.
//   clk, rstn       : system clock (>= 4x bck), async active-low reset
//   enable          : receive enable, low forces IDLE
//   signed_data     : 1 = two's complement out, 0 = offset binary (MSB flipped)
//   bck, lrck, sdi  : I2S pins, asynchronous to clk
//   lj              : (only with I2S_RX_LJ_EN) 1 = left-justified, 0 = I2S
//   dout_l, dout_r  : output samples
//   valid           : one-clk pulse when dout_l/dout_r update
// Optional macro I2S_RX_LJ_EN adds the lj port and left-justified support.
module i2s_rx
    import pdm_pkg::*;
#(
    parameter int DW          = DW_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          enable,
    input  logic          signed_data,
    input  logic          bck,
    input  logic          lrck,
    input  logic          sdi,
`ifdef I2S_RX_LJ_EN
    input  logic          lj,
`endif
    output logic [DW-1:0] dout_l,
    output logic [DW-1:0] dout_r,
    output logic          valid
);

    localparam int CW = $clog2(DW + 1);

    logic          be;
    logic          lrck_s, sdi_s;
    logic          lr_prev;
    logic          boundary;
    logic          lj_mode;
    i2s_state_t    state;
    logic [DW-1:0] sh, sh_app, closed, hold_l, raw_l, raw_r;
    logic [CW-1:0] cnt, cnt_app;
    logic [DW-1:0] ob_mask;

    sync_edge #(.N(SYNC_STAGES), .W(2)) u_sync (
        .clk       (clk),
        .rstn      (rstn),
        .edge_in   (bck),
        .plain_in  ({lrck, sdi}),
        .rise      (be),
        .plain_out ({lrck_s, sdi_s})
    );

`ifdef I2S_RX_LJ_EN
    assign lj_mode = lj;
`else
    assign lj_mode = 1'b0;
`endif

    // Current bit appended to the word under assembly; bits past DW are dropped.
    always_comb begin
        sh_app  = sh;
        cnt_app = cnt;
        if (cnt < CW'(DW)) begin
            for (int i = 0; i < DW; i++)
                if (int'(cnt) == DW - 1 - i) sh_app[i] = sdi_s;
            cnt_app = cnt + CW'(1);
        end
    end

    assign boundary = be && (lrck_s != lr_prev);
    // I2S: the boundary bit is the LSB of the closing word. LJ: it is the
    // MSB of the next word, so the closing word excludes it.
    assign closed   = lj_mode ? sh : sh_app;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            lr_prev <= 1'b0;
            sh      <= '0;
            cnt     <= '0;
            hold_l  <= '0;
            raw_l   <= '0;
            raw_r   <= '0;
            valid   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (be) lr_prev <= lrck_s;
            if (!enable) begin
                // enable wins over a coincident boundary: no store, no valid
                state <= IDLE;
                sh    <= '0;
                cnt   <= '0;
            end else if (be) begin
                if (boundary) begin
                    if (lj_mode) begin
                        sh  <= {sdi_s, {(DW-1){1'b0}}};
                        cnt <= CW'(1);
                    end else begin
                        sh  <= '0;
                        cnt <= '0;
                    end
                    case (state)
                        IDLE:  if (!lrck_s) state <= LEFT;
                        LEFT:  if (lrck_s) begin
                                   hold_l <= closed;
                                   state  <= RIGHT;
                               end
                        RIGHT: if (!lrck_s) begin
                                   raw_l <= hold_l;
                                   raw_r <= closed;
                                   valid <= 1'b1;
                                   state <= LEFT;
                               end
                        default: state <= IDLE;
                    endcase
                end else begin
                    sh  <= sh_app;
                    cnt <= cnt_app;
                end
            end
        end
    end

    always_comb begin
        ob_mask         = '0;
        ob_mask[DW-1]   = ~signed_data;
    end

    assign dout_l = raw_l ^ ob_mask;
    assign dout_r = raw_r ^ ob_mask;

endmodule
